rr_output_allocator: RTL
========================

# rr_output_allocator

Parallel, wormhole-locking switch allocator for the 5-port NoC router. One round-robin arbiter per output port (W, E, N, S, PE) grants that output to one requesting input. The grant stays locked until the owning input signals that its packet has crossed the crossbar. Different outputs are granted concurrently. The block drives the crossbar select fields and the per-input grant lines that the input buffers use to release flits.

## Interface
Parameters:
- REQ_size, 3, width of one destination/index field (port code: 0 W, 1 E, 2 N, 3 S, 4 PE; 5–7 illegal)
- NUM_PORTS, 5, number of router ports; fixed at 5 for this revision

Ports (field i occupies bits [i*REQ_size +: REQ_size]):
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- REQ_VALID  input  5  bit i: input i has a head flit requesting an output
- REQ_DST  input  15  field i: destination port code of input i
- CROSS_DONE  input  5  bit i: tail flit of input i crossed this cycle
- GNT  output  5  bit i: input i currently owns its requested output
- OUT_BUSY  output  5  bit o: output o is locked; also serves as crossbar enable for output o
- OUT_SEL  output  15  field o: index of the input driving output o; 3'b111 when idle
- DST_ERR  output  5  bit i: input i is valid with an illegal destination code

## Operation
- Each output o runs a 2-state FSM:
  - IDLE → LOCKED when at least one input with REQ_VALID=1 and REQ_DST=o exists; the round-robin winner becomes owner.
  - LOCKED → IDLE when CROSS_DONE[owner] is sampled high.
- Round-robin: each output keeps a pointer holding the last winner's index. The search starts at pointer+1 mod 5 in the order 0→1→2→3→4. The pointer updates only on a new grant. Reset pointer = 4, so input 0 (W) has first priority.
- The lock is independent of REQ_VALID: dropping REQ_VALID while granted does not release the output. Only CROSS_DONE of the owner releases it.
- REQ_DST must be stable while GNT[i]=1. The allocator does not re-evaluate the destination of a locked input.
- CROSS_DONE from a non-owner is ignored.
- Illegal destination (5–7): the request is never granted, and DST_ERR[i] is high in the cycle after each sampled illegal valid request.
- U-turn requests (destination equal to the source port) are legal and granted like any other.
- Each input requests at most one output, so at most one GNT bit per input. GNT[i] = OR over outputs o of (LOCKED_o and owner_o = i).
- Simultaneous events:
  - Release and new requests on the same edge: the output goes IDLE. Arbitration happens at the following edge, giving one bubble cycle per packet.
  - Several outputs arbitrate on the same edge independently.
- Reset (including mid-packet) clears all locks.
  - Reset values: GNT=0, OUT_BUSY=0, OUT_SEL=15'h7FFF, DST_ERR=0, all pointers=4.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Grant latency: request sampled at edge N → GNT, OUT_BUSY and OUT_SEL valid after edge N. Flit transfer may begin in the cycle following edge N.
- Release: CROSS_DONE sampled at edge M → GNT, OUT_BUSY and OUT_SEL return to idle values after edge M. The earliest re-grant of that output is at edge M+1.
- Minimum occupancy per packet: 1 locked cycle plus 1 idle cycle per output.
- Fairness bound: a continuously requesting input is granted within 4 packet services of its output.

## Structure
- Shared package noc_pkg:
  - port codes PORT_W=0, PORT_E=1, PORT_N=2, PORT_S=3, PORT_PE=4
  - NUM_PORTS=5, SEL_IDLE=3'b111
  - the FSM state typedef (IDLE, LOCKED)
- Sub-module out_port_arb, instantiated 5 times (one per output):
  - inputs: 5-bit request vector (valid & dst==o) and CROSS_DONE
  - contains the FSM, pointer and owner register
  - outputs: busy, owner index, per-input grant vector
- The top module performs destination decode, DST_ERR generation and the OR-reduction of grants.

## Test plan
- Reset → GNT=0, OUT_BUSY=0, OUT_SEL=15'h7FFF, DST_ERR=0. Assert RST mid-packet with W locked to E → all of these return to reset values asynchronously. Then W requests again → W is granted first (pointer back to 4).
- Single packet W→E (REQ_VALID=5'b00001, field0=1) → after the next edge GNT=5'b00001, OUT_BUSY=5'b00010, OUT_SEL[5:3]=0. Hold for 4 cycles, pulse CROSS_DONE[0] → GNT=0 and OUT_BUSY=0 after that edge.
- W, N, S all requesting PE continuously, each packet ended by CROSS_DONE → owner sequence 0, 2, 3, 0, 2, with exactly one idle cycle between owners.
- Simultaneous W→E, E→W, N→S, S→N, PE→PE → one edge later GNT=5'b11111, OUT_BUSY=5'b11111, OUT_SEL={3'd4,3'd2,3'd3,3'd0,3'd1}.
- N valid with dst=6 → DST_ERR=5'b00100, no grant. Spurious CROSS_DONE[1] while E is not owner → no state change.
- W granted to E, then REQ_VALID[0] drops for 3 cycles → lock held. E requests E at the same time → blocked until CROSS_DONE[0], then granted one cycle after the release edge.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port codes, index widths and the
// per-output allocator FSM state.
package noc_pkg;
  localparam int NUM_PORTS = 5;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] PORT_W   = 3'd0;
  localparam logic [IDX_W-1:0] PORT_E   = 3'd1;
  localparam logic [IDX_W-1:0] PORT_N   = 3'd2;
  localparam logic [IDX_W-1:0] PORT_S   = 3'd3;
  localparam logic [IDX_W-1:0] PORT_PE  = 3'd4;
  localparam logic [IDX_W-1:0] SEL_IDLE = 3'b111;

  typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/out_port_arb.sv
// One output's wormhole lock: round-robin pick among requesting inputs,
// held until the owner's tail flit crosses.
module out_port_arb
  import noc_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] cross_done,
  output logic                 busy,
  output logic [IDX_W-1:0]     owner,
  output logic [NUM_PORTS-1:0] gnt
);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] own_q, own_nxt;
  logic [IDX_W-1:0] win, cand;
  logic             found;

  // Search starts one past the last winner, wrapping at NUM_PORTS.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= PORT_PE;
      own_q <= SEL_IDLE;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      own_q <= own_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    own_nxt   = own_q;
    case (state)
      IDLE: if (found) begin
        state_nxt = LOCKED;
        ptr_nxt   = win;
        own_nxt   = win;
      end
      LOCKED: if (cross_done[own_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state == LOCKED);
  assign owner = busy ? own_q : SEL_IDLE;

  always_comb begin
    gnt = '0;
    if (busy) gnt[own_q] = 1'b1;
  end

endmodule

// File: rtl/rr_output_allocator.sv
// 5-port NoC switch allocator: destination decode, one locking round-robin
// arbiter per output, grant OR-reduction and illegal-destination flags.
module rr_output_allocator
  import noc_pkg::*;
#(
  parameter int REQ_size  = 3,
  parameter int NUM_PORTS = 5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_PORTS-1:0]          REQ_VALID,
  input  logic [NUM_PORTS*REQ_size-1:0] REQ_DST,
  input  logic [NUM_PORTS-1:0]          CROSS_DONE,
  output logic [NUM_PORTS-1:0]          GNT,
  output logic [NUM_PORTS-1:0]          OUT_BUSY,
  output logic [NUM_PORTS*REQ_size-1:0] OUT_SEL,
  output logic [NUM_PORTS-1:0]          DST_ERR
);

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_m;  // [output][input]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_m;
  logic [NUM_PORTS-1:0]                bad_dst;

  always_comb begin
    req_m   = '0;
    bad_dst = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bad_dst[i] = REQ_VALID[i] && (int'(REQ_DST[i*REQ_size +: REQ_size]) >= NUM_PORTS);
      for (int o = 0; o < NUM_PORTS; o++)
        req_m[o][i] = REQ_VALID[i] && (REQ_DST[i*REQ_size +: REQ_size] == REQ_size'(o));
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    out_port_arb u_arb (
      .CLK       (CLK),
      .RST       (RST),
      .req       (req_m[o]),
      .cross_done(CROSS_DONE),
      .busy      (OUT_BUSY[o]),
      .owner     (OUT_SEL[o*REQ_size +: REQ_size]),
      .gnt       (gnt_m[o])
    );
  end

  // Destinations are stable while locked, so at most one output grants any input.
  always_comb begin
    GNT = '0;
    for (int o = 0; o < NUM_PORTS; o++) GNT = GNT | gnt_m[o];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) DST_ERR <= '0;
    else     DST_ERR <= bad_dst;
  end

endmodule
